// File: rtl/rc_pwm_out.sv
// Servo PWM generator fed by RC channel-update strobes: converts 11-bit RC values to
// 1000..2000 us pulses, phase-aligned on a fixed frame, with failsafe on link loss.
module rc_pwm_out #(
    parameter int clock_frequency     = 12000000,
    parameter int num_outputs         = 4,
    parameter int frame_period_us     = 20000,
    parameter int failsafe_timeout_ms = 100,
    parameter int failsafe_pulse_us   = 1500
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   channel_changed,
    input  logic [3:0]             channel_index,
    input  logic [10:0]            channel_value,
    output logic [num_outputs-1:0] pwm,
    output logic                   link_ok
);

    localparam int TICKS   = clock_frequency / 1000000;
    localparam int PW      = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int UW      = $clog2(frame_period_us);
    localparam int CW      = (UW > 12) ? UW : 12;
    localparam int TIMEOUT = failsafe_timeout_ms * (clock_frequency / 1000);
    localparam int LW      = $clog2(TIMEOUT + 1);
    localparam logic [11:0] FS_WIDTH = 12'(failsafe_pulse_us);

    logic [PW-1:0] r_prescale;
    logic [CW-1:0] r_us_count;
    logic          r_first;
    logic [LW-1:0] r_link_cnt;
    logic [11:0]   r_pending [num_outputs];
    logic [11:0]   r_active  [num_outputs];

    logic          w_tick;
    logic          w_wrap;
    logic          w_frame_start;
    logic [13:0]   w_prod;
    logic [11:0]   w_sum;
    logic [11:0]   w_width;

    assign w_tick        = (r_prescale == PW'(TICKS - 1));
    assign w_wrap        = (r_us_count == CW'(frame_period_us - 1));
    // The first tick after reset opens frame 0 without advancing us_count.
    assign w_frame_start = w_tick && (r_first || w_wrap);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_prod  = {3'b000, channel_value} * 14'd5;
        w_sum   = 12'd880 + {1'b0, w_prod[13:3]};
        w_width = w_sum;
        if (w_sum < 12'd1000) begin
            w_width = 12'd1000;
        end else if (w_sum > 12'd2000) begin
            w_width = 12'd2000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_us_count <= '0;
            r_first    <= 1'b1;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_first <= 1'b0;
                if (!r_first) begin
                    r_us_count <= w_wrap ? '0 : r_us_count + 1'b1;
                end
            end
        end
    end

    // NOTE: these small register arrays are reset because reset defines their contents (failsafe width).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_outputs; i++) begin
                r_pending[i] <= FS_WIDTH;
                r_active[i]  <= FS_WIDTH;
            end
        end else begin
            for (int i = 0; i < num_outputs; i++) begin
                if (channel_changed && (channel_index == 4'(i))) begin
                    r_pending[i] <= w_width;
                end
                if (w_frame_start) begin
                    r_active[i] <= link_ok ? r_pending[i] : FS_WIDTH;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_link_cnt <= '0;
            link_ok    <= 1'b0;
        end else if (channel_changed) begin
            r_link_cnt <= '0;
            link_ok    <= 1'b1;
        end else if (r_link_cnt != LW'(TIMEOUT)) begin
            r_link_cnt <= r_link_cnt + 1'b1;
            if (r_link_cnt == LW'(TIMEOUT - 1)) begin
                link_ok <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < num_outputs; i++) begin
                pwm[i] <= !r_first && (r_us_count < CW'(r_active[i]));
            end
        end
    end

endmodule

// File: doc/rc_pwm_out.md
# rc_pwm_out

Downstream consumer of the F.Port receiver's channel-update strobes. It keeps a per-output pending pulse width and converts each 11-bit RC channel value to a servo pulse width in microseconds. It drives `num_outputs` standard servo PWM pins with a fixed frame period and substitutes a failsafe pulse when channel updates stop arriving. It sits between the F.Port radio block and the servo/ESC output pins.

## Interface
- `clock_frequency`, 12000000, clock rate in Hz; must be a multiple of 1000000.
- `num_outputs`, 4, PWM pins driven (1..16); output i follows RC channel index i.
- `frame_period_us`, 20000, PWM frame period in µs.
- `failsafe_timeout_ms`, 100, maximum silence before link is declared lost.
- `failsafe_pulse_us`, 1500, pulse width used while link is down; 0 = hold pin low.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `channel_changed`  in  1  one-cycle strobe: `channel_index`/`channel_value` valid.
- `channel_index`  in  4  RC channel number, 0..15.
- `channel_value`  in  11  raw RC value, nominal 172..1811.
- `pwm`  out  num_outputs  servo pulse outputs, active high.
- `link_ok`  out  1  high while updates arrive within the timeout.

## Operation
- Prescaler counts `clock_frequency/1000000` clocks per µs tick. Frame counter `us_count` steps 0..`frame_period_us`-1 per tick and wraps to 0.
- Conversion: `width = 880 + ((channel_value*5) >> 3)`, clamped to [1000, 2000].
  - Product is 14 bits; sum is 12 bits; truncation toward zero.
  - Conversion is registered into `pending[channel_index]` one clock after the strobe.
- Strobes with `channel_index >= num_outputs` write nothing but still count as link activity.
- Link monitor: saturating clock counter cleared by every `channel_changed`. When it reaches `failsafe_timeout_ms*clock_frequency/1000`, `link_ok` is driven 0. The next strobe sets `link_ok` to 1 one clock later.
- Frame start is the clock on which `us_count` wraps to 0. On that clock, `active[i]` loads `pending[i]` if `link_ok`=1, otherwise `failsafe_pulse_us`.
  - `pending` is not cleared on link loss; last values resume when the link returns.
- `pwm[i]` is registered as `us_count < active[i]`. Each pulse is exactly `active[i]` µs long and starts on every frame. Outputs are phase-aligned.
- `active` never changes mid-frame, so no truncated or doubled pulses occur.

## Timing
- Reset values:
  - `pwm` all 0, `link_ok` 0.
  - `pending[*]` and `active[*]` = `failsafe_pulse_us`.
  - Prescaler, `us_count` and link counter = 0.
  - First frame starts on the first µs tick after reset deasserts.
- Update latency: strobe → `pending` +1 clock → visible at the next frame start. Worst case is one frame period plus 1 clock.
- A strobe on the same clock as a frame-start latch lands in `pending` after the latch, so it takes effect one frame later.
- A strobe on the same clock the timeout would expire wins: counter clears and `link_ok` stays 1.
- Two strobes on consecutive clocks are both accepted; the same index is last-write-wins.
- `pwm` rises one clock after the frame-start `us_count` wrap and falls one clock after `us_count` reaches `active[i]`.
- Reset asserted mid-pulse forces `pwm` low immediately (asynchronous); no partial pulse completes.

## Test plan
- Reset, no strobes → `link_ok`=0, every pin emits 1500 µs (18000 clocks) pulses every 20000 µs (240000 clocks), all aligned.
- Strobe index 0, value 992 → `link_ok`=1 next clock; from next frame `pwm[0]`=1500 µs. Index 0, value 1000 → 1505 µs (18060 clocks).
- Clamp: value 172 → 1000 µs; value 1811 → 2000 µs; value 0 → 1000 µs; value 2047 → 2000 µs.
- Mid-frame change: index 1 set to 1811 at `us_count`=1200 while pulse of 1500 is high → current pulse ends at 1500 µs, next frame 2000 µs. Index 9 strobe → no pin changes, link counter cleared.
- Timeout: strobes stop → after exactly 1200000 clocks `link_ok`=0 and the next frame reverts to 1500 µs. One strobe then restores the previous `pending` widths the frame after.
- `failsafe_pulse_us`=0 build, reset → all `pwm` stay 0. Assert reset during a pulse → `pwm` 0 immediately, frame restarts after release.
